// File: rtl/pokey_pkg.sv
// pokey_pkg
//   Shared types and default constants for the POKEY core.
//   - poly_state_e    : sequencer FSM states
//   - POKEY_*         : default divider / flush lengths
//   - cnt_width()     : register width needed to hold 0..n-1 (at least 1 bit)
package pokey_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    INIT  = 2'd1,
    FLUSH = 2'd2
  } poly_state_e;

  localparam int POKEY_CLK_DIV    = 8;
  localparam int POKEY_DIV64K     = 28;
  localparam int POKEY_DIV15K     = 114;
  localparam int POKEY_POLY_FLUSH = 17;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pokey_poly_sequencer_tick_counter.sv
// pokey_tick_counter
//   Modulo-N counter that advances on a strobe and emits a one-cycle wrap
//   strobe. A hold-clear forces the count to 0 and suppresses the wrap.
// Ports:
//   clk       : system clock
//   reset     : synchronous active-high reset
//   i_advance : count enable (machine-cycle strobe)
//   i_clear   : hold count at 0, suppress wrap
//   o_wrap    : high in the advancing cycle where count == N-1
module pokey_tick_counter
  import pokey_pkg::*;
#(
  parameter int N = POKEY_DIV64K
) (
  input  logic clk,
  input  logic reset,
  input  logic i_advance,
  input  logic i_clear,
  output logic o_wrap
);

  localparam int W = cnt_width(N);
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] r_cnt;
  logic         w_at_last;

  assign w_at_last = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_advance) begin
      r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_wrap = i_advance && !i_clear && w_at_last;

endmodule

// File: rtl/pokey_poly_sequencer.sv
// pokey_poly_sequencer
//   Machine-cycle prescaler, 64 kHz / 15 kHz base tick generation and the
//   SKCTL-driven init/flush sequence for the shared poly counter controls.
// Ports:
//   clk         : system clock
//   reset       : synchronous active-high reset
//   skctl_init  : high while SKCTL selects init mode
//   audctl_15k  : 1 selects the 15 kHz base clock, 0 the 64 kHz one
//   enable_179  : one-cycle machine-cycle strobe
//   poly_enable : shift enable for all poly counters (== enable_179)
//   poly_init   : init for all poly counters
//   tick_64k    : one-cycle 64 kHz strobe
//   tick_15k    : one-cycle 15 kHz strobe
//   tick_base   : selected audio base tick
//   init_busy   : high while in INIT or FLUSH
//
// state | meaning
// RUN   | normal operation, base ticks running
// INIT  | SKCTL init held, poly counters forced to init, ticks held at 0
// FLUSH | init released, poly counters still forced for FLUSH_LEN strobes
module pokey_poly_sequencer
  import pokey_pkg::*;
#(
  parameter int CLK_DIV   = POKEY_CLK_DIV,
  parameter int DIV64K    = POKEY_DIV64K,
  parameter int DIV15K    = POKEY_DIV15K,
  parameter int FLUSH_LEN = POKEY_POLY_FLUSH
) (
  input  logic clk,
  input  logic reset,
  input  logic skctl_init,
  input  logic audctl_15k,
  output logic enable_179,
  output logic poly_enable,
  output logic poly_init,
  output logic tick_64k,
  output logic tick_15k,
  output logic tick_base,
  output logic init_busy
);

  localparam int DIV_W = cnt_width(CLK_DIV);
  localparam int FL_W  = cnt_width(FLUSH_LEN);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [FL_W-1:0]  FL_LAST  = FL_W'(FLUSH_LEN - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [FL_W-1:0]  r_flush_cnt;
  poly_state_e      r_state;
  logic             r_poly_init;
  logic             w_strobe;
  logic             w_hold;
  logic             w_tick_64k;
  logic             w_tick_15k;

  // Prescaler free-runs through every state so the poly counters keep
  // shifting (zeros) while init is forced.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
    end
  end

  assign w_strobe = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_flush_cnt <= '0;
      r_poly_init <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (skctl_init) begin
            r_state     <= INIT;
            r_poly_init <= 1'b1;
          end
        end
        INIT: begin
          if (!skctl_init) begin
            r_state     <= FLUSH;
            r_flush_cnt <= '0;
          end
        end
        FLUSH: begin
          if (skctl_init) begin
            r_state <= INIT;
          end else if (w_strobe) begin
            if (r_flush_cnt == FL_LAST) begin
              r_state     <= RUN;
              r_poly_init <= 1'b0;
            end else if (r_flush_cnt != '1) begin
              r_flush_cnt <= r_flush_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state     <= RUN;
          r_poly_init <= 1'b0;
        end
      endcase
    end
  end

  // Including skctl_init here kills a tick that lands on the same cycle
  // as the init request, before the FSM has left RUN.
  assign w_hold = (r_state != RUN) || skctl_init;

  pokey_tick_counter #(.N(DIV64K)) u_c64 (
    .clk       (clk),
    .reset     (reset),
    .i_advance (w_strobe),
    .i_clear   (w_hold),
    .o_wrap    (w_tick_64k)
  );

  pokey_tick_counter #(.N(DIV15K)) u_c15 (
    .clk       (clk),
    .reset     (reset),
    .i_advance (w_strobe),
    .i_clear   (w_hold),
    .o_wrap    (w_tick_15k)
  );

  assign enable_179  = w_strobe;
  assign poly_enable = w_strobe;
  assign poly_init   = r_poly_init;
  assign init_busy   = (r_state != RUN);
  assign tick_64k    = w_tick_64k;
  assign tick_15k    = w_tick_15k;
  // No glitch masking: the register file only changes audctl_15k on a write.
  assign tick_base   = audctl_15k ? w_tick_15k : w_tick_64k;

endmodule

// File: tb/tb_pokey_poly_sequencer.sv
module tb_pokey_poly_sequencer;

  logic clk;
  logic reset;
  logic skctl_init;
  logic audctl_15k;
  logic enable_179;
  logic poly_enable;
  logic poly_init;
  logic tick_64k;
  logic tick_15k;
  logic tick_base;
  logic init_busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Scoreboard queues: expected event cycles, counted from reset release.
  int q_en[$];
  int q_64[$];
  int q_15[$];
  int q_pi[$];
  logic exp_pi = 1'b0;
  logic last_pi = 1'b0;

  // Reference poly4 (XNOR LFSR, zero seed) fed by the sequencer outputs.
  logic [3:0] r_p4;
  bit pb[$];
  logic [0:14] exp_seq;

  pokey_poly_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .skctl_init  (skctl_init),
    .audctl_15k  (audctl_15k),
    .enable_179  (enable_179),
    .poly_enable (poly_enable),
    .poly_init   (poly_init),
    .tick_64k    (tick_64k),
    .tick_15k    (tick_15k),
    .tick_base   (tick_base),
    .init_busy   (init_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    if (reset) cyc = 0;
    else       cyc = cyc + 1;
  end

  always @(posedge clk) begin
    if (reset || poly_init) begin
      r_p4 <= 4'b0;
      pb.delete();
    end else if (poly_enable) begin
      r_p4 <= {r_p4[2:0], ~(r_p4[3] ^ r_p4[2])};
      pb.push_back(~(r_p4[3] ^ r_p4[2]));
    end
  end

  always @(negedge clk) begin
    logic e_en, e_64, e_15, e_base, e_pi;
    if (!reset) begin
      e_en = (q_en.size() != 0) && (q_en[0] == cyc);
      e_64 = (q_64.size() != 0) && (q_64[0] == cyc);
      e_15 = (q_15.size() != 0) && (q_15[0] == cyc);
      e_pi = (q_pi.size() != 0) && (q_pi[0] == cyc);
      if (e_en) void'(q_en.pop_front());
      if (e_64) void'(q_64.pop_front());
      if (e_15) void'(q_15.pop_front());
      if (e_pi) begin
        void'(q_pi.pop_front());
        exp_pi = ~exp_pi;
      end
      e_base = audctl_15k ? e_15 : e_64;
      if (e_en || enable_179)  check("enable_179", enable_179, e_en);
      if (e_en || poly_enable) check("poly_enable", poly_enable, e_en);
      if (e_64 || tick_64k)    check("tick_64k", tick_64k, e_64);
      if (e_15 || tick_15k)    check("tick_15k", tick_15k, e_15);
      if (e_base || tick_base) check("tick_base", tick_base, e_base);
      if (e_pi || poly_init != last_pi || poly_init != exp_pi)
        check("poly_init", poly_init, exp_pi);
      if (e_pi || init_busy != exp_pi)
        check("init_busy", init_busy, exp_pi);
      last_pi = poly_init;
    end
  end

  // Advance to 1 time unit after the edge that starts cycle n.
  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_en_left"}, q_en.size(), 0);
    check({tag, "_64_left"}, q_64.size(), 0);
    check({tag, "_15_left"}, q_15.size(), 0);
    check({tag, "_pi_left"}, q_pi.size(), 0);
  endtask

  initial begin
    exp_seq    = 15'b111011001010000;
    reset      = 1'b1;
    skctl_init = 1'b0;
    audctl_15k = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_enable_179", enable_179, 0);
    check("rst_poly_enable", poly_enable, 0);
    check("rst_poly_init", poly_init, 0);
    check("rst_tick_64k", tick_64k, 0);
    check("rst_tick_15k", tick_15k, 0);
    check("rst_tick_base", tick_base, 0);
    check("rst_init_busy", init_busy, 0);

    // Segment 1: free run, init, re-init during flush, reset mid-flush.
    for (int s = 1; s <= 356; s++) q_en.push_back(8 * s - 1);
    // strobes 28,56,84,112,140; 168 suppressed; restart after 190 -> 218,246;
    // restart after 290 -> 318,346
    q_64 = '{223, 447, 671, 895, 1119, 1743, 1967, 2543, 2767};
    q_15 = '{911};
    q_pi = '{1344, 1520, 2081, 2320, 2801};
    reset = 1'b0;

    goto(900);  audctl_15k = 1'b1;
    goto(1343); skctl_init = 1'b1;   // same cycle as a 64k tick
    goto(1384); skctl_init = 1'b0;
    goto(1500); audctl_15k = 1'b0;
    goto(2080); skctl_init = 1'b1;
    goto(2096); skctl_init = 1'b0;
    goto(2175); skctl_init = 1'b1;   // flush strobe 10
    goto(2184); skctl_init = 1'b0;
    goto(2800); skctl_init = 1'b1;
    goto(2808); skctl_init = 1'b0;
    goto(2848);                      // just after flush strobe 5
    check_drained("seg1");

    // Segment 2: restart after reset, init, then poly4 sequence.
    for (int s = 1; s <= 84; s++) q_en.push_back(8 * s - 1);
    q_64 = '{223, 639};
    q_pi = '{0, 241, 416};
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    goto(240); skctl_init = 1'b1;
    goto(280); skctl_init = 1'b0;
    goto(675);
    check_drained("seg2");

    check("poly4_len", (pb.size() >= 30) ? 1 : 0, 1);
    if (pb.size() >= 30) begin
      for (int i = 0; i < 30; i++) check("poly4_bit", pb[i], exp_seq[i % 15]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pokey_poly_sequencer.md
# pokey_poly_sequencer

Timing and sequencing controller for the POKEY polynomial counters (poly4, poly5, poly9, poly17) and channel base clocks. It divides the system clock into the 1.79 MHz machine-cycle strobe, derives the 64 kHz and 15 kHz base ticks, and selects the audio base clock from AUDCTL. It also owns the SKCTL-driven initialisation sequence that drives the shared `enable`/`init` inputs of every poly counter instance. Sits between the register file and the poly/audio-divider datapath inside the POKEY core.

## Interface
- `CLK_DIV`, 8: system clocks per machine cycle (≥2).
- `DIV64K`, 28: machine cycles per 64 kHz tick.
- `DIV15K`, 114: machine cycles per 15 kHz tick.
- `FLUSH_LEN`, 17: machine-cycle strobes of forced init after SKCTL init is released (≥ longest poly length).

Ports:
- `clk` in 1: system clock; one clock domain.
- `reset` in 1: synchronous, active-high reset.
- `skctl_init` in 1: high while SKCTL[1:0]=00 (init mode).
- `audctl_15k` in 1: AUDCTL[0]; 1 selects the 15 kHz base clock, 0 selects 64 kHz.
- `enable_179` out 1: one-cycle machine-cycle strobe.
- `poly_enable` out 1: enable to all poly counters; equals `enable_179`.
- `poly_init` out 1: init to all poly counters.
- `tick_64k` out 1: one-cycle strobe.
- `tick_15k` out 1: one-cycle strobe.
- `tick_base` out 1: `audctl_15k ? tick_15k : tick_64k`; combinational select of registered ticks.
- `init_busy` out 1: high in INIT or FLUSH.

## Operation
- Prescaler `div_cnt` counts 0..CLK_DIV-1, wraps, and is never held. `enable_179` is high in the cycle where `div_cnt == CLK_DIV-1`.
- Counter `c64` counts 0..DIV64K-1 and advances on `enable_179` only. `tick_64k` is high for the cycle in which it wraps; this coincides with an `enable_179` cycle.
- Counter `c15` behaves the same way with DIV15K.
- FSM states:
  - RUN: `poly_init` = 0. Go to INIT when `skctl_init` = 1.
  - INIT: `poly_init` = 1. `c64`/`c15` are held at 0 and the ticks are suppressed. Go to FLUSH when `skctl_init` = 0, with `flush_cnt` ← 0.
  - FLUSH: `poly_init` = 1. Counters are still held at 0. `flush_cnt` increments on `enable_179`. Go to RUN on the strobe where `flush_cnt == FLUSH_LEN-1`. Return to INIT if `skctl_init` re-asserts.
- `poly_enable` keeps strobing in every state, so the poly counters shift zeros during INIT and FLUSH.
- `flush_cnt` is 5 bits and saturates; its width is derived from FLUSH_LEN.
- Simultaneous events:
  - A `skctl_init` rise in the same cycle as a tick: the tick is suppressed.
  - Leaving FLUSH: the counters start from 0 in the cycle after the transition.

## Timing
- Reset values: `div_cnt`=0, `c64`=0, `c15`=0, `flush_cnt`=0, state=RUN. All outputs are 0 and `poly_init`=0.
- The first `enable_179` occurs CLK_DIV cycles after reset is released, in cycle CLK_DIV-1 counting from 0.
- `poly_init` and `init_busy` rise 1 cycle after `skctl_init` rises, and fall 1 cycle after the FLUSH_LEN-th post-release strobe.
- Period of `tick_64k` is CLK_DIV·DIV64K cycles. Period of `tick_15k` is CLK_DIV·DIV15K cycles.
- After RUN resumes, the first `tick_64k` comes on the DIV64K-th strobe.
- Reset asserted mid-FLUSH or mid-INIT returns to RUN next cycle with all counters at 0. The poly counters are cleared by their own reset.
- `audctl_15k` changes take effect on `tick_base` in the same cycle, with no glitch masking. The register file changes it only on a bus write.

## Structure
- Shared package `pokey_pkg`:
  - FSM state enum {RUN, INIT, FLUSH}.
  - Default constants `POKEY_DIV64K`=28, `POKEY_DIV15K`=114, `POKEY_POLY_FLUSH`=17.
- One natural sub-module, `pokey_tick_counter`: a parameterised modulo-N counter with advance, hold-clear and a wrap strobe. It is instantiated for `c64` and `c15`; the FSM and prescaler stay inline.

## Test plan
- **Reset/prescaler:** release reset with CLK_DIV=8 → `enable_179` pulses on cycles 7, 15, 23…; all other outputs stay 0.
- **Base ticks:** run 114·8 cycles → `tick_64k` at cycles 223, 447, 671, 895; `tick_15k` at cycle 911; `tick_base` follows `audctl_15k` for both values.
- **Init sequence:** assert `skctl_init` for 5 strobes, then release → `poly_init`=1 starting the next cycle, ticks absent, `poly_enable` still strobing, `poly_init` drops after the 17th post-release strobe, first `tick_64k` 28 strobes later.
- **Re-init during FLUSH:** re-assert `skctl_init` at flush strobe 10 → FSM returns to INIT; on release, a full 17-strobe flush is repeated.
- **Reset mid-FLUSH:** pulse `reset` at flush strobe 5 → next cycle `poly_init`=0, `init_busy`=0, counters 0, prescaler restarts (strobe 8 cycles later).
- **Integration:** with a poly_4 instance connected, after the init sequence its output bit sequence matches the all-zero-seed XNOR LFSR sequence, period 15.
